// File: rtl/usart_rx_pkg.sv
// Shared definitions for the USART receive path.
//   UsartDataBits : data bits per frame (8)
//   CpbWidth      : width of the runtime clocks-per-bit value (12)
//   rx_state_e    : receiver FSM states
//   parity_bit()  : parity bit a transmitter would send for a byte
package usart_rx_pkg;

  localparam int unsigned UsartDataBits = 8;
  localparam int unsigned CpbWidth      = 12;

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StParity,
    StStop,
    StBreak
  } rx_state_e;

  // Even sense (odd=0) makes the total count of ones, parity bit included, even.
  function automatic logic parity_bit(logic [UsartDataBits-1:0] data, logic odd);
    return (^data) ^ odd;
  endfunction

endpackage

// File: rtl/usart_rx_if.sv
// Receive-side consumer bus: one-entry valid/ready holding register plus status pulses.
//   master : the receiver (drives data, valid, busy and error pulses; samples rx_ready)
//   slave  : the comm-side consumer (drives rx_ready)
interface usart_rx_if;

  logic [usart_rx_pkg::UsartDataBits-1:0] rx_data;
  logic                                   rx_valid;
  logic                                   rx_ready;
  logic                                   rx_busy;
  logic                                   framing_error;
  logic                                   overrun;
  logic                                   parity_error;

  modport master (
    output rx_data,
    output rx_valid,
    output rx_busy,
    output framing_error,
    output overrun,
    output parity_error,
    input  rx_ready
  );

  modport slave (
    input  rx_data,
    input  rx_valid,
    input  rx_busy,
    input  framing_error,
    input  overrun,
    input  parity_error,
    output rx_ready
  );

endinterface

// File: rtl/usart_rx_sync.sv
// Two-flop synchroniser for an asynchronous level input.
//   clk_i : sampling clock
//   rst_i : synchronous, active-high; presets both flops to 1 (serial idle level)
//   d_i   : asynchronous input
//   q_o   : synchronised output
module usart_rx_sync (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_i,
  output logic q_o
);

  logic [1:0] sync_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync_q <= 2'b11;
    end else begin
      sync_q <= {sync_q[0], d_i};
    end
  end

  assign q_o = sync_q[1];

endmodule

// File: rtl/usart_rx.sv
// USART receive front-end: synchronises rx_pin, detects the start bit, samples each bit at
// mid-bit using a runtime clocks_per_bit, and hands each byte to a one-entry valid/ready
// holding register.
//   serial_clock   : single clock
//   reset          : synchronous, active-high
//   clocks_per_bit : cycles per bit (4..4095), latched at start-bit detect
//   rx_pin         : asynchronous serial line, idles high
//   rx_bus         : consumer bus (usart_rx_if.master)
// Build option: define USART_RX_PARITY_EN for 8 data + parity + stop frames (sense set by
// PARITY_ODD); otherwise frames are 8N1 and parity_error is tied low.
module usart_rx
  import usart_rx_pkg::*;
#(
  parameter int unsigned DATA_BITS = UsartDataBits
`ifdef USART_RX_PARITY_EN
  ,
  parameter bit          PARITY_ODD = 1'b0
`endif
) (
  input  logic                serial_clock,
  input  logic                reset,
  input  logic [CpbWidth-1:0] clocks_per_bit,
  input  logic                rx_pin,
  usart_rx_if.master          rx_bus
);

  localparam logic [CpbWidth-1:0] CntOne  = CpbWidth'(1);
  localparam logic [2:0]          LastIdx = 3'(DATA_BITS - 1);

  logic rx_s;

  rx_state_e                  state_q, state_d;
  logic [CpbWidth-1:0]        cnt_q, cnt_d;
  logic [CpbWidth-1:0]        cpb_q, cpb_d;
  logic [2:0]                 idx_q, idx_d;
  logic [UsartDataBits-1:0]   shift_q, shift_d;
  logic                       pend_q, pend_d;   // byte awaiting delivery this cycle
  logic                       fe_q, fe_d;
  logic [UsartDataBits-1:0]   data_q, data_d;
  logic                       valid_q, valid_d;
  logic                       perr_q, perr_d;
  logic                       cnt_zero;
  logic                       overrun;

  usart_rx_sync u_sync (
    .clk_i (serial_clock),
    .rst_i (reset),
    .d_i   (rx_pin),
    .q_o   (rx_s)
  );

  assign cnt_zero = (cnt_q == '0);

  // Frame FSM and baud counter.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    cpb_d   = cpb_q;
    idx_d   = idx_q;
    shift_d = shift_q;
    perr_d  = perr_q;
    pend_d  = 1'b0;
    fe_d    = 1'b0;

    if (state_q != StIdle && state_q != StBreak && !cnt_zero) begin
      cnt_d = cnt_q - CntOne;
    end

    case (state_q)
      StIdle: begin
        if (!rx_s) begin
          state_d = StStart;
          cpb_d   = clocks_per_bit;
          cnt_d   = (clocks_per_bit >> 1) - CntOne;
        end
      end
      StStart: begin
        if (cnt_zero) begin
          if (!rx_s) begin
            state_d = StData;
            cnt_d   = cpb_q - CntOne;
            idx_d   = '0;
          end else begin
            state_d = StIdle;  // glitch shorter than half a bit
          end
        end
      end
      StData: begin
        if (cnt_zero) begin
          shift_d[idx_q] = rx_s;
          cnt_d          = cpb_q - CntOne;
          idx_d          = idx_q + 3'd1;
          if (idx_q == LastIdx) begin
`ifdef USART_RX_PARITY_EN
            state_d = StParity;
`else
            state_d = StStop;
`endif
          end
        end
      end
`ifdef USART_RX_PARITY_EN
      StParity: begin
        if (cnt_zero) begin
          perr_d  = (rx_s != parity_bit(shift_q, PARITY_ODD));
          cnt_d   = cpb_q - CntOne;
          state_d = StStop;
        end
      end
`endif
      StStop: begin
        if (cnt_zero) begin
          if (rx_s) begin
            pend_d  = 1'b1;
            state_d = StIdle;
          end else begin
            fe_d    = 1'b1;
            state_d = StBreak;
          end
        end
      end
      StBreak: begin
        // Held-low line: wait for idle before looking for another start bit.
        if (rx_s) begin
          state_d = StIdle;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // Holding register: a delivery may coincide with the consumer draining the old byte.
  always_comb begin
    data_d  = data_q;
    valid_d = valid_q;
    overrun = 1'b0;
    if (pend_q) begin
      if (!valid_q || rx_bus.rx_ready) begin
        data_d  = shift_q;
        valid_d = 1'b1;
      end else begin
        overrun = 1'b1;
      end
    end else if (valid_q && rx_bus.rx_ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge serial_clock) begin
    if (reset) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      cpb_q   <= '0;
      idx_q   <= '0;
      shift_q <= '0;
      perr_q  <= 1'b0;
      pend_q  <= 1'b0;
      fe_q    <= 1'b0;
      data_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      cpb_q   <= cpb_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      perr_q  <= perr_d;
      pend_q  <= pend_d;
      fe_q    <= fe_d;
      data_q  <= data_d;
      valid_q <= valid_d;
    end
  end

  assign rx_bus.rx_data       = data_q;
  assign rx_bus.rx_valid      = valid_q;
  assign rx_bus.rx_busy       = (state_q != StIdle);
  assign rx_bus.framing_error = fe_q;
  assign rx_bus.overrun       = overrun;
`ifdef USART_RX_PARITY_EN
  assign rx_bus.parity_error  = pend_q & perr_q;
`else
  assign rx_bus.parity_error  = 1'b0;
`endif

endmodule

// File: tb/tb_usart_rx.sv
// Bench for usart_rx: directed frames plus a randomized frame stream, checked against a
// frame-level model (bytes the consumer should accept, expected error-pulse counts).
module tb_usart_rx;

  localparam bit PAR_ODD = 1'b0;

  logic        serial_clock = 1'b0;
  logic        reset        = 1'b1;
  logic [11:0] clocks_per_bit = 12'd32;
  logic        rx_pin       = 1'b1;

  usart_rx_if rx_bus ();

  usart_rx dut (
    .serial_clock   (serial_clock),
    .reset          (reset),
    .clocks_per_bit (clocks_per_bit),
    .rx_pin         (rx_pin),
    .rx_bus         (rx_bus)
  );

  always #2 serial_clock = ~serial_clock;

  int checks = 0;
  int errors = 0;
  int bit_ns = 128;

  // Observed by the monitor.
  logic [7:0] got_q[$];
  int n_fe = 0;
  int n_ov = 0;
  int n_pe = 0;

  // Model expectations.
  logic [7:0] exp_q[$];
  int exp_fe = 0;
  int exp_ov = 0;
  int exp_pe = 0;

  always @(negedge serial_clock) begin
    if (!reset) begin
      if (rx_bus.rx_valid && rx_bus.rx_ready) got_q.push_back(rx_bus.rx_data);
      if (rx_bus.framing_error) n_fe++;
      if (rx_bus.overrun) n_ov++;
      if (rx_bus.parity_error) n_pe++;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic chk_stream(input string tag);
    chk({tag, "_count"}, got_q.size(), exp_q.size());
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      chk({tag, "_byte"}, {24'd0, got_q[i]}, {24'd0, exp_q[i]});
    end
    chk({tag, "_fe"}, n_fe, exp_fe);
    chk({tag, "_ov"}, n_ov, exp_ov);
    chk({tag, "_pe"}, n_pe, exp_pe);
    got_q.delete();
    exp_q.delete();
  endtask

  // Start bit, data LSB first, optional parity; leaves the line at the stop level.
  task automatic send_bits(input logic [7:0] b, input bit flip);
    rx_pin = 1'b0;
    #(bit_ns);
    for (int i = 0; i < 8; i++) begin
      rx_pin = b[i];
      #(bit_ns);
    end
`ifdef USART_RX_PARITY_EN
    rx_pin = (^b) ^ PAR_ODD ^ flip;
    #(bit_ns);
`endif
    rx_pin = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] b, input bit flip);
    send_bits(b, flip);
    #(bit_ns);
  endtask

  task automatic pulse_ready();
    @(posedge serial_clock); #1;
    rx_bus.rx_ready = 1'b1;
    @(posedge serial_clock); #1;
    rx_bus.rx_ready = 1'b0;
  endtask

  initial begin
    bit found;
    logic [7:0] b;
    bit bad;
    bit flip;

    rx_bus.rx_ready = 1'b1;
    repeat (5) @(posedge serial_clock);
    #1;
    chk("rst_data", {24'd0, rx_bus.rx_data}, 32'h0);
    chk("rst_valid", rx_bus.rx_valid, 1'b0);
    chk("rst_busy", rx_bus.rx_busy, 1'b0);
    chk("rst_fe", rx_bus.framing_error, 1'b0);
    chk("rst_ov", rx_bus.overrun, 1'b0);
    chk("rst_pe", rx_bus.parity_error, 1'b0);
    reset = 1'b0;

    // Single frame, consumer ready.
    #100;
    send_frame(8'h75, 1'b0);
    exp_q.push_back(8'h75);
    #(bit_ns);
    chk("f75_valid_after", rx_bus.rx_valid, 1'b0);
    chk_stream("f75");

    // Consumer not ready: byte held until accepted.
    rx_bus.rx_ready = 1'b0;
    #256;
    send_frame(8'h8A, 1'b0);
    chk("f8a_valid", rx_bus.rx_valid, 1'b1);
    chk("f8a_data", {24'd0, rx_bus.rx_data}, 32'h8A);
    repeat (20) @(posedge serial_clock);
    #1;
    chk("f8a_hold", rx_bus.rx_valid, 1'b1);
    pulse_ready();
    exp_q.push_back(8'h8A);
    chk("f8a_clear", rx_bus.rx_valid, 1'b0);
    chk("f8a_keep", {24'd0, rx_bus.rx_data}, 32'h8A);
    chk_stream("f8a");

    // Back-to-back frames with no consumer: second byte overruns.
    send_bits(8'h75, 1'b0);
    #(bit_ns);
    send_frame(8'h8A, 1'b0);
    exp_ov++;
    chk("ovr_data", {24'd0, rx_bus.rx_data}, 32'h75);
    chk("ovr_valid", rx_bus.rx_valid, 1'b1);
    pulse_ready();
    exp_q.push_back(8'h75);
    chk_stream("ovr");

    // Same, but the consumer drains on the delivery cycle of the second byte.
    send_frame(8'h75, 1'b0);
    send_bits(8'h8A, 1'b0);
    found = 1'b0;
    for (int i = 0; i < 4 * 32; i++) begin
      @(posedge serial_clock); #1;
      if (!rx_bus.rx_busy) begin
        found = 1'b1;
        break;
      end
    end
    chk("drain_busy_drop", found, 1'b1);
    rx_bus.rx_ready = 1'b1;
    @(posedge serial_clock); #1;
    rx_bus.rx_ready = 1'b0;
    exp_q.push_back(8'h75);
    chk("drain_data", {24'd0, rx_bus.rx_data}, 32'h8A);
    chk("drain_valid", rx_bus.rx_valid, 1'b1);
    #(bit_ns);
    pulse_ready();
    exp_q.push_back(8'h8A);
    chk_stream("drain");

    // Short low glitch on the idle line.
    rx_bus.rx_ready = 1'b1;
    #(bit_ns);
    rx_pin = 1'b0;
    #40;
    rx_pin = 1'b1;
    chk("glitch_busy", rx_bus.rx_busy, 1'b1);
    #(bit_ns);
    chk("glitch_idle", rx_bus.rx_busy, 1'b0);
    chk_stream("glitch");

    // Stop bit held low (break), then a good frame left in the holding register.
    send_bits(8'h55, 1'b0);
    rx_pin = 1'b0;
    #(3 * bit_ns);
    rx_pin = 1'b1;
    #(bit_ns);
    exp_fe++;
    rx_bus.rx_ready = 1'b0;
    send_frame(8'h33, 1'b0);
    chk("brk_data", {24'd0, rx_bus.rx_data}, 32'h33);
    chk("brk_valid", rx_bus.rx_valid, 1'b1);
    chk_stream("brk");

    // Reset mid-DATA: held byte and partial frame are discarded.
    rx_pin = 1'b0;
    #(bit_ns);
    rx_pin = 1'b1;
    #(bit_ns);
    rx_pin = 1'b0;
    #(bit_ns / 2);
    reset = 1'b1;
    rx_pin = 1'b1;
    repeat (3) @(posedge serial_clock);
    #1;
    chk("mid_rst_valid", rx_bus.rx_valid, 1'b0);
    chk("mid_rst_data", {24'd0, rx_bus.rx_data}, 32'h0);
    chk("mid_rst_busy", rx_bus.rx_busy, 1'b0);
    reset = 1'b0;
    rx_bus.rx_ready = 1'b1;
    #(bit_ns);
    send_frame(8'hA5, 1'b0);
    exp_q.push_back(8'hA5);
`ifdef USART_RX_PARITY_EN
    #(bit_ns);
    send_frame(8'hA5, 1'b1);
    exp_q.push_back(8'hA5);
    exp_pe++;
`endif
    #(bit_ns);
    chk_stream("a5");

    // Randomized frames, varying baud, occasional broken stop bits.
    for (int n = 0; n < 24; n++) begin
      clocks_per_bit = 12'($urandom_range(6, 40));
      bit_ns = 4 * int'(clocks_per_bit);
      #(bit_ns * $urandom_range(1, 3));
      b    = 8'($urandom);
      bad  = ($urandom_range(0, 4) == 0);
      flip = ($urandom_range(0, 3) == 0);
      send_bits(b, flip);
      if (bad) begin
        rx_pin = 1'b0;
        #(bit_ns * $urandom_range(1, 2));
        rx_pin = 1'b1;
        #(bit_ns);
        exp_fe++;
      end else begin
        #(bit_ns);
        exp_q.push_back(b);
`ifdef USART_RX_PARITY_EN
        if (flip) exp_pe++;
`endif
      end
    end
    #(2 * bit_ns);
    chk_stream("rand");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
